// File: rtl/key_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : key_capture_if
// Description : Keypad scan bus between the scan front end and key_capture.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_capture_if;
    logic       enable;
    logic [3:0] col;
    logic [3:0] row;
    logic       scan_hold;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (
        output enable, col, row,
        input  scan_hold, key_valid, key_code
    );

    modport slave (
        input  enable, col, row,
        output scan_hold, key_valid, key_code
    );
endinterface
`default_nettype wire

// File: rtl/key_capture.sv
`default_nettype none
// ============================================================================
// Module      : key_capture
// Description : Freezes the keypad column scan on a press, debounces press and
//               release, and emits a one-cycle valid pulse with the key code.
// Revision    : 1.0 - initial release
// ============================================================================
module key_capture #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic         clk,
    input  logic         reset,
    key_capture_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_col;
    logic [3:0]       r_row;
    logic             r_scan_hold;
    logic             r_key_valid;
    logic [3:0]       r_key_code;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_col_nxt;
    logic [3:0]       w_row_nxt;
    logic             w_key_valid_nxt;
    logic [3:0]       w_key_code_nxt;

    logic             w_col_onehot;
    logic             w_row_onehot;
    logic             w_match;
    logic             w_row_clear;
    logic             w_cnt_done;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_code;

    function automatic logic f_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    function automatic logic [1:0] f_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        if (v[0])
            idx = 2'd0;
        else if (v[1])
            idx = 2'd1;
        else if (v[2])
            idx = 2'd2;
        return idx;
    endfunction

    // Keypad layout: rows R1..R4 top to bottom, columns C1..C4 left to right.
    function automatic logic [3:0] f_encode(input logic [3:0] c, input logic [3:0] r);
        logic [3:0] code;
        code = 4'h0;
        case ({f_index(r), f_index(c)})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    assign w_col_onehot = f_onehot(bus.col);
    assign w_row_onehot = f_onehot(bus.row);
    assign w_match      = (bus.col == r_col) && (bus.row == r_row);
    assign w_row_clear  = (bus.row == 4'b0000);
    assign w_cnt_done   = (r_cnt >= c_CNT_LAST);
    assign w_cnt_inc    = w_cnt_done ? c_CNT_LAST : (r_cnt + CNT_W'(1));
    assign w_code       = f_encode(r_col, r_row);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_col       <= 4'b0000;
            r_row       <= 4'b0000;
            r_scan_hold <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_scan_hold <= (w_state_nxt != S_IDLE);
            r_key_valid <= w_key_valid_nxt;
            r_key_code  <= w_key_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_key_valid_nxt = 1'b0;
        w_key_code_nxt  = r_key_code;

        case (r_state)
            S_IDLE: begin
                // Ghosted (multi-hot) rows and malformed strobes never start a capture.
                if (bus.enable && w_col_onehot && w_row_onehot) begin
                    w_state_nxt = S_DEBOUNCE;
                    w_cnt_nxt   = '0;
                    w_col_nxt   = bus.col;
                    w_row_nxt   = bus.row;
                end
            end

            S_DEBOUNCE: begin
                if (!bus.enable || !w_match) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_done) begin
                    w_state_nxt     = S_PRESSED;
                    w_key_valid_nxt = 1'b1;
                    w_key_code_nxt  = w_code;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_PRESSED: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_row_clear) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end

            S_RELEASE: begin
                // Any row activity during release is bounce: go back to held, no new pulse.
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_row_clear) begin
                    w_state_nxt = S_PRESSED;
                end else if (w_cnt_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.scan_hold = r_scan_hold;
    assign bus.key_valid = r_key_valid;
    assign bus.key_code  = r_key_code;

endmodule
`default_nettype wire

// File: tb/tb_key_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_capture
// Description : Vector-table and scoreboard bench for key_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_capture;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] col;
        logic [3:0] row;
        logic       sh;
        logic       kv;
        logic [3:0] kc;
    } vec_t;

    logic clk;
    logic reset;

    key_capture_if kif ();

    key_capture #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t       vecs[$];
    logic [5:0] sb[$];
    int         pass_cnt;
    int         total_cnt;

    task automatic add(input logic r, input logic e, input logic [3:0] c, input logic [3:0] w,
                       input logic sh, input logic kv, input logic [3:0] kc, input int n);
        vec_t v;
        v.rst_n = r; v.en = e; v.col = c; v.row = w;
        v.sh = sh; v.kv = kv; v.kc = kc;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    int   edges;
    int   pulses;
    logic seen;

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        reset      = 1'b0;
        kif.enable = 1'b0;
        kif.col    = 4'b0000;
        kif.row    = 4'b0000;

        // reset state
        add(0, 1, 4'b0010, 4'b0100, 0, 0, 4'h0, 2);
        // bounce on press: key 1 for two cycles then open
        add(1, 1, 4'b0001, 4'b0001, 1, 0, 4'h0, 2);
        add(1, 1, 4'b0001, 4'b0000, 0, 0, 4'h0, 2);
        // ghosting / malformed strobe / disabled scan
        add(1, 1, 4'b0001, 4'b0011, 0, 0, 4'h0, 1);
        add(1, 1, 4'b0110, 4'b0001, 0, 0, 4'h0, 1);
        add(1, 0, 4'b0001, 4'b0001, 0, 0, 4'h0, 1);
        add(1, 1, 4'b0000, 4'b0001, 0, 0, 4'h0, 1);
        // clean press of 8, held 10 cycles, clean release
        add(1, 1, 4'b0010, 4'b0100, 1, 0, 4'h0, 4);
        add(1, 1, 4'b0010, 4'b0100, 1, 1, 4'h8, 1);
        add(1, 1, 4'b0010, 4'b0100, 1, 0, 4'h8, 5);
        add(1, 1, 4'b0010, 4'b0000, 1, 0, 4'h8, 4);
        add(1, 1, 4'b0010, 4'b0000, 0, 0, 4'h8, 2);
        // '#' with extra row while held, then bounce on release
        add(1, 1, 4'b0100, 4'b1000, 1, 0, 4'h8, 4);
        add(1, 1, 4'b0100, 4'b1000, 1, 1, 4'hF, 1);
        add(1, 1, 4'b0100, 4'b1001, 1, 0, 4'hF, 1);
        add(1, 1, 4'b0100, 4'b1000, 1, 0, 4'hF, 1);
        add(1, 1, 4'b0100, 4'b0000, 1, 0, 4'hF, 2);
        add(1, 1, 4'b0100, 4'b1000, 1, 0, 4'hF, 1);
        add(1, 1, 4'b0100, 4'b0000, 1, 0, 4'hF, 4);
        add(1, 1, 4'b0100, 4'b0000, 0, 0, 4'hF, 1);
        // enable drop at counter=2, then full debounce restart on key 5
        add(1, 1, 4'b0010, 4'b0010, 1, 0, 4'hF, 3);
        add(1, 0, 4'b0010, 4'b0010, 0, 0, 4'hF, 1);
        add(1, 1, 4'b0010, 4'b0010, 1, 0, 4'hF, 4);
        add(1, 1, 4'b0010, 4'b0010, 1, 1, 4'h5, 1);
        add(1, 1, 4'b0010, 4'b0010, 1, 0, 4'h5, 1);
        add(1, 0, 4'b0010, 4'b0010, 0, 0, 4'h5, 2);
        // key A accepted, then reset while pressed and held through a full press
        add(1, 1, 4'b1000, 4'b0001, 1, 0, 4'h5, 4);
        add(1, 1, 4'b1000, 4'b0001, 1, 1, 4'hA, 1);
        add(1, 1, 4'b1000, 4'b0001, 1, 0, 4'hA, 1);
        add(0, 1, 4'b1000, 4'b0001, 0, 0, 4'h0, 6);
        add(1, 1, 4'b1000, 4'b0000, 0, 0, 4'h0, 1);
        // '*' press and release
        add(1, 1, 4'b0001, 4'b1000, 1, 0, 4'h0, 4);
        add(1, 1, 4'b0001, 4'b1000, 1, 1, 4'hE, 1);
        add(1, 1, 4'b0001, 4'b0000, 1, 0, 4'hE, 4);
        add(1, 1, 4'b0001, 4'b0000, 0, 0, 4'hE, 1);
        // reset in mid-debounce on key 0, then a full press of 0 (code 0)
        add(1, 1, 4'b0010, 4'b1000, 1, 0, 4'hE, 2);
        add(0, 1, 4'b0010, 4'b1000, 0, 0, 4'h0, 1);
        add(1, 1, 4'b0010, 4'b1000, 1, 0, 4'h0, 4);
        add(1, 1, 4'b0010, 4'b1000, 1, 1, 4'h0, 1);
        add(0, 1, 4'b0000, 4'b0000, 0, 0, 4'h0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset      = vecs[i].rst_n;
            kif.enable = vecs[i].en;
            kif.col    = vecs[i].col;
            kif.row    = vecs[i].row;
            sb.push_back({vecs[i].sh, vecs[i].kv, vecs[i].kc});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {2'b00, kif.scan_hold, kif.key_valid, kif.key_code},
                  {2'b00, sb.pop_front()});
        end

        // Hand sequence: accept latency and no auto-repeat on key 9
        @(negedge clk);
        reset      = 1'b1;
        kif.enable = 1'b1;
        kif.col    = 4'b0100;
        kif.row    = 4'b0100;
        @(posedge clk);
        #1;
        check("cap_hold", {7'd0, kif.scan_hold}, 8'd1);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (kif.key_valid) seen = 1'b1;
        end
        check("latency9", 8'(edges), 8'd4);
        check("code9", {4'h0, kif.key_code}, 8'h09);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (kif.key_valid) pulses++;
        end
        check("norepeat9", 8'(pulses), 8'd0);
        check("held9", {7'd0, kif.scan_hold}, 8'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
